// File: rtl/mdio_master_cfg_if.sv
// Management-side bus of the MDIO master: command launch, serial pad signals and status.
// The master modport is the MDIO master itself; slave is the CPU/pad side driving it.
interface mdio_master_cfg_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDC;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        DONE;
    logic        BUSY;
    logic        TA_ERR;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDIO_OUT, MDIO_OE, MDC, RD_DATA, DATA_RDY, DONE, BUSY, TA_ERR
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDIO_OUT, MDIO_OE, MDC, RD_DATA, DATA_RDY, DONE, BUSY, TA_ERR
    );
endinterface

// File: rtl/mdio_master_cfg.sv
// Parametrised MDIO management master: Clause 22/45 frames from one command word,
// MDC divided from clk, optional preamble, turnaround check on reads.
module mdio_master_cfg #(
    parameter int CLK_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic              clk,
    input  logic              RESET,
    mdio_master_cfg_if.master bus
);

    localparam int MAX_BITS = (PREAMBLE_LEN > 32) ? PREAMBLE_LEN : 32;
    localparam int DIV_W    = $clog2(2 * CLK_DIV);
    localparam int BIT_W    = $clog2(MAX_BITS);

    localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam logic [BIT_W-1:0] CMD_LAST = BIT_W'(13);
    localparam logic [BIT_W-1:0] WR_LAST  = BIT_W'(17);
    localparam logic [BIT_W-1:0] TA_LAST  = BIT_W'(1);
    localparam logic [BIT_W-1:0] RD_LAST  = BIT_W'(15);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_CMD, S_WR_TAIL, S_TA_RD, S_RD_DATA_SH, S_FINISH
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [31:0]      r_tx;
    logic [15:0]      r_rx;
    logic             r_is_read;
    logic             r_ta_bad;
    logic             r_start_d;
    logic             r_mdc;
    logic             r_out;
    logic             r_oe;
    logic [15:0]      r_rd_data;
    logic             r_data_rdy;
    logic             r_done;
    logic             r_busy;
    logic             r_ta_err;

    logic             w_start;
    logic             w_bit_end;
    logic             w_sample;
    logic             w_frame_end;
    logic [DIV_W-1:0] w_div_nxt;

    assign w_start     = bus.MDIO_START & ~r_start_d;
    assign w_bit_end   = (r_div_cnt == DIV_LAST);
    assign w_sample    = (r_div_cnt == DIV_MID);   // cycle ending in the MDC rising edge
    assign w_div_nxt   = r_div_cnt + 1'b1;
    assign w_frame_end = w_bit_end &&
                         (((r_state == S_WR_TAIL)    && (r_bit_cnt == WR_LAST)) ||
                          ((r_state == S_RD_DATA_SH) && (r_bit_cnt == RD_LAST)));

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_is_read  <= 1'b0;
            r_ta_bad   <= 1'b0;
            r_start_d  <= 1'b1;   // a start level held through reset is not an edge
            r_mdc      <= 1'b0;
            r_out      <= 1'b0;
            r_oe       <= 1'b0;
            r_rd_data  <= '0;
            r_data_rdy <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ta_err   <= 1'b0;
        end else begin
            r_start_d  <= bus.MDIO_START;
            r_done     <= 1'b0;
            r_data_rdy <= 1'b0;
            case (r_state)
                S_IDLE, S_FINISH: begin
                    r_state <= S_IDLE;
                    r_mdc   <= 1'b0;
                    r_oe    <= 1'b0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                    if (w_start) begin
                        r_tx      <= bus.T_DATA;
                        r_is_read <= bus.T_DATA[29];
                        r_ta_err  <= 1'b0;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_oe      <= 1'b1;
                        r_busy    <= 1'b1;
                        if (PREAMBLE_LEN > 0) begin
                            r_state <= S_PREAMBLE;
                            r_out   <= 1'b1;
                        end else begin
                            r_state <= S_CMD;
                            r_out   <= bus.T_DATA[31];
                        end
                    end
                end
                default: begin
                    if (w_sample && (r_state == S_TA_RD) && (r_bit_cnt == TA_LAST))
                        r_ta_bad <= bus.MDIO_IN;
                    if (w_sample && (r_state == S_RD_DATA_SH))
                        r_rx <= {r_rx[14:0], bus.MDIO_IN};

                    if (!w_bit_end) begin
                        r_div_cnt <= w_div_nxt;
                        r_mdc     <= (w_div_nxt >= DIV_HALF);
                    end else begin
                        r_div_cnt <= '0;
                        r_mdc     <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        case (r_state)
                            S_PREAMBLE: if (r_bit_cnt == PRE_LAST) begin
                                r_state   <= S_CMD;
                                r_bit_cnt <= '0;
                                r_out     <= r_tx[31];
                            end
                            S_CMD: begin
                                r_tx  <= {r_tx[30:0], 1'b0};
                                r_out <= r_tx[30];
                                if (r_bit_cnt == CMD_LAST) begin
                                    r_bit_cnt <= '0;
                                    if (r_is_read) begin
                                        r_state <= S_TA_RD;
                                        r_oe    <= 1'b0;
                                        r_out   <= 1'b0;
                                    end else begin
                                        r_state <= S_WR_TAIL;
                                    end
                                end
                            end
                            S_WR_TAIL: begin
                                r_tx  <= {r_tx[30:0], 1'b0};
                                r_out <= r_tx[30];
                            end
                            S_TA_RD: if (r_bit_cnt == TA_LAST) begin
                                r_state   <= S_RD_DATA_SH;
                                r_bit_cnt <= '0;
                            end
                            default: ;
                        endcase
                    end

                    if (w_frame_end) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_oe    <= 1'b0;
                        r_out   <= 1'b0;
                        if (r_is_read) begin
                            r_data_rdy <= 1'b1;
                            r_rd_data  <= r_rx;
                            r_ta_err   <= r_ta_bad;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.MDC      = r_mdc;
    assign bus.MDIO_OUT = r_out;
    assign bus.MDIO_OE  = r_oe;
    assign bus.RD_DATA  = r_rd_data;
    assign bus.DATA_RDY = r_data_rdy;
    assign bus.DONE     = r_done;
    assign bus.BUSY     = r_busy;
    assign bus.TA_ERR   = r_ta_err;

endmodule

// File: tb/tb_mdio_master_cfg.sv
// Directed bench for mdio_master_cfg: default instance (CLK_DIV=2, PREAMBLE_LEN=32)
// and a corner instance (CLK_DIV=1, PREAMBLE_LEN=0), checked against a bit-level frame model.
module tb_mdio_master_cfg;

    typedef struct {
        logic [31:0] t_data;
        logic [15:0] phy_word;
        bit          phy_absent;
        int          disturb_at;  // cycle of a second start edge while busy, 0 = none
        bit          gap;         // idle cycle after DONE, else next frame is back-to-back
        logic        exp_rdy;
        logic [15:0] exp_rd;
        logic        exp_ta;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] tdata;
    logic        mdio_in;
    bit          sel;      // 0: default instance, 1: corner instance
    int          n_vec = 0;
    int          n_err = 0;

    mdio_master_cfg_if if_a ();
    mdio_master_cfg_if if_b ();

    mdio_master_cfg #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut_a (.clk(clk), .RESET(rst), .bus(if_a));
    mdio_master_cfg #(.CLK_DIV(1), .PREAMBLE_LEN(0))  u_dut_b (.clk(clk), .RESET(rst), .bus(if_b));

    always #5 clk = ~clk;

    assign if_a.MDIO_START = start & ~sel;
    assign if_b.MDIO_START = start & sel;
    assign if_a.T_DATA     = tdata;
    assign if_b.T_DATA     = tdata;
    assign if_a.MDIO_IN    = mdio_in;
    assign if_b.MDIO_IN    = mdio_in;

    logic        o_mdc, o_out, o_oe, o_rdy, o_done, o_busy, o_ta;
    logic [15:0] o_rd;
    assign o_mdc  = sel ? if_b.MDC      : if_a.MDC;
    assign o_out  = sel ? if_b.MDIO_OUT : if_a.MDIO_OUT;
    assign o_oe   = sel ? if_b.MDIO_OE  : if_a.MDIO_OE;
    assign o_rdy  = sel ? if_b.DATA_RDY : if_a.DATA_RDY;
    assign o_done = sel ? if_b.DONE     : if_a.DONE;
    assign o_busy = sel ? if_b.BUSY     : if_a.BUSY;
    assign o_ta   = sel ? if_b.TA_ERR   : if_a.TA_ERR;
    assign o_rd   = sel ? if_b.RD_DATA  : if_a.RD_DATA;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one frame and follow it cycle by cycle; returns in the DONE cycle (or one later with gap).
    task automatic run_frame(input vec_t v, input int idx);
        int          d, p, f, b, ph, errs, first_bad;
        logic        exp_mdc, exp_oe, exp_out, rd;
        logic [31:0] lat;
        d = sel ? 1 : 2;
        p = sel ? 0 : 32;
        f = (p + 32) * 2 * d;
        lat = v.t_data;
        rd = v.t_data[29];
        errs = 0;
        first_bad = 0;
        start = 1'b1;
        tdata = v.t_data;
        @(posedge clk); #1;
        for (int k = 1; k <= f; k++) begin
            if (k == 1) start = 1'b0;
            if (v.disturb_at > 0) begin
                if (k == v.disturb_at - 1) tdata = 32'h6ABC_1234;
                if (k == v.disturb_at)     start = 1'b1;
                if (k == v.disturb_at + 1) start = 1'b0;
            end
            b  = (k - 1) / (2 * d);
            ph = (k - 1) % (2 * d);
            exp_mdc = (ph >= d);
            exp_oe  = !rd || (b < p + 14);
            exp_out = (b < p) ? 1'b1 : lat[31 - (b - p)];
            if (v.phy_absent || b < p + 14 || b == p + 14) mdio_in = 1'b1;
            else if (b == p + 15)                          mdio_in = 1'b0;
            else                                           mdio_in = v.phy_word[15 - (b - p - 16)];
            if (o_busy !== 1'b1 || o_mdc !== exp_mdc || o_oe !== exp_oe ||
                (exp_oe && o_out !== exp_out) || o_done !== 1'b0 ||
                o_rdy !== 1'b0 || o_ta !== 1'b0) begin
                errs++;
                if (first_bad == 0) first_bad = k;
            end
            @(posedge clk); #1;
        end
        check($sformatf("v%0d_stream_errs(first_cycle_%0d)", idx, first_bad), errs, 0);
        check($sformatf("v%0d_done", idx), {31'b0, o_done}, 1);
        check($sformatf("v%0d_busy_end", idx), {31'b0, o_busy}, 0);
        check($sformatf("v%0d_mdc_oe_end", idx), {30'b0, o_mdc, o_oe}, 0);
        check($sformatf("v%0d_data_rdy", idx), {31'b0, o_rdy}, {31'b0, v.exp_rdy});
        check($sformatf("v%0d_rd_data", idx), {16'b0, o_rd}, {16'b0, v.exp_rd});
        check($sformatf("v%0d_ta_err", idx), {31'b0, o_ta}, {31'b0, v.exp_ta});
        mdio_in = 1'b1;
        if (v.gap) begin
            @(posedge clk); #1;
            check($sformatf("v%0d_after_done_busy", idx), {30'b0, o_done, o_busy}, 0);
            check($sformatf("v%0d_after_rdy", idx), {31'b0, o_rdy}, 0);
            check($sformatf("v%0d_ta_hold", idx), {31'b0, o_ta}, {31'b0, v.exp_ta});
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t corner;
        int   errs;

        //          t_data        phy_word  absent dist gap  rdy   rd        ta
        vecs[0] = '{32'h5440_8440, 16'h0000, 1'b0, 0,  1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{32'h65C8_8440, 16'hA5C3, 1'b0, 0,  1'b1, 1'b1, 16'hA5C3, 1'b0};
        vecs[2] = '{32'h65C8_8440, 16'h0000, 1'b1, 0,  1'b1, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{32'h5440_8440, 16'h0000, 1'b0, 50, 1'b0, 1'b0, 16'hFFFF, 1'b0};
        vecs[4] = '{32'h3086_0000, 16'h1E0F, 1'b0, 0,  1'b1, 1'b1, 16'h1E0F, 1'b0};
        vecs[5] = '{32'h2086_0000, 16'h8001, 1'b0, 0,  1'b1, 1'b1, 16'h8001, 1'b0};
        corner  = '{32'h0086_0123, 16'h0000, 1'b0, 0,  1'b1, 1'b0, 16'h0000, 1'b0};

        sel = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        tdata = '0;
        mdio_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mdc_out_oe", {29'b0, o_mdc, o_out, o_oe}, 0);
        check("reset_rd_data", {16'b0, o_rd}, 0);
        check("reset_flags", {28'b0, o_rdy, o_done, o_busy, o_ta}, 0);
        check("reset_corner_busy_oe", {30'b0, if_b.BUSY, if_b.MDIO_OE}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Reset in the middle of a read, with a start level raised alongside it and held.
        start = 1'b1;
        tdata = 32'h65C8_8440;
        @(posedge clk); #1;
        start = 1'b0;
        mdio_in = 1'b0;
        repeat (98) @(posedge clk);
        #1;
        check("mid_read_busy", {31'b0, o_busy}, 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_mdc_out_oe", {29'b0, o_mdc, o_out, o_oe}, 0);
        check("midrst_flags", {28'b0, o_rdy, o_done, o_busy, o_ta}, 0);
        check("midrst_rd_data", {16'b0, o_rd}, 0);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_oe !== 1'b0 || o_mdc !== 1'b0) errs++;
        end
        check("held_start_no_relaunch", errs, 0);
        start = 1'b0;
        mdio_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        sel = 1'b1;
        @(posedge clk); #1;
        run_frame(corner, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdio_master_cfg.md
# mdio_master_cfg

- Parametrised MDIO management master; next generation of the fixed-frame MDIO controller.
- Generates MDC from `clk` with a configurable divider and a configurable preamble length (including preamble suppression).
- Runs Clause 22 and Clause 45 frames from one 32-bit command word, checks the PHY turnaround on reads, and reports completion and errors.
- Sits between the management CPU/register block and the external MDIO pad (tristate via `MDIO_OE`).

## Interface
- `CLK_DIV`, default 2: MDC half-period in `clk` cycles (≥1); bit period = 2·CLK_DIV cycles.
- `PREAMBLE_LEN`, default 32: number of preamble `1` bits before ST (0 = preamble suppressed).
- `clk` in, 1: system clock, all logic on rising edge.
- `RESET` in, 1: synchronous, active-high reset.
- `MDIO_START` in, 1: a rising edge launches a frame using `T_DATA`.
- `T_DATA` in, 32: {ST[31:30], OP[29:28], PHYAD/PRTAD[27:23], REGAD/DEVAD[22:18], TA[17:16], DATA[15:0]}.
- `MDIO_IN` in, 1: serial data from the pad.
- `MDIO_OUT` out, 1: serial data to the pad.
- `MDIO_OE` out, 1: pad output enable.
- `MDC` out, 1: management clock.
- `RD_DATA` out, 16: last read data.
- `DATA_RDY` out, 1: one-cycle pulse, read data valid.
- `DONE` out, 1: one-cycle pulse at the end of any frame.
- `BUSY` out, 1: a frame is in progress.
- `TA_ERR` out, 1: the PHY failed to drive 0 in the second TA bit of the last read.

## Operation
- **Start edge**
  - Start is the cycle with `MDIO_START`=1 and the registered previous value =0.
  - The edge register resets to 1, so a level held high through reset does not launch a frame.
  - Accepted only in IDLE; edges while `BUSY` are ignored.
  - On acceptance: `T_DATA` is latched and `TA_ERR` is cleared.
- **Read detection:** a frame is a read iff OP[1]=1 (C22 read 10; C45 read 11, read-increment 10). All other frames are write-type (C22 write 01, C45 address 00 / write 01). ST is not decoded further.
- **States**
  - IDLE → PREAMBLE, or → CMD if PREAMBLE_LEN=0.
  - PREAMBLE: PREAMBLE_LEN bits of `1`, `MDIO_OE`=1.
  - CMD: bits 31..18 driven MSB first.
  - Write-type: WR_TAIL drives bits 17..0 as latched, so TA comes from `T_DATA`.
  - Read: TA_RD (2 bits, `MDIO_OE`=0) → RD_DATA_SH (16 bits, `MDIO_OE`=0).
  - Last bit → FINISH (1 cycle) → IDLE.
- **Bit timing**
  - Each bit period: MDC low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `MDIO_OUT`/`MDIO_OE` change only at bit-period start, i.e. MDC falling edge or first cycle.
  - `MDIO_IN` is sampled on the `clk` edge where MDC goes 0→1.
- **Read data path**
  - Sampled bits shift MSB first into an internal register.
  - `RD_DATA` updates only in FINISH; it holds otherwise, including across write frames.
- **TA check:** if the second TA sample is 1, `TA_ERR` is set in FINISH. The frame still completes, `RD_DATA` still updates, and `DATA_RDY` still pulses. `TA_ERR` holds until the next accepted start or reset.
- **Idle outputs:** `MDC`=0, `MDIO_OE`=0, `MDIO_OUT`=0.
- **Counter widths:** derived with $clog2 from CLK_DIV and max(PREAMBLE_LEN, 32); no wrap within a frame.

## Timing
- **Reset values:** `MDC` 0, `MDIO_OUT` 0, `MDIO_OE` 0, `RD_DATA` 16'h0000, `DATA_RDY` 0, `DONE` 0, `BUSY` 0, `TA_ERR` 0; state IDLE.
- **Reset mid-frame:** takes effect at the next edge; the frame aborts, the latched command is discarded, and no `DONE` is issued.
- **Frame start:** start edge sampled at cycle N. At N+1: `BUSY`=1, `MDIO_OE`=1, `MDC`=0, first bit on `MDIO_OUT`.
- **Frame duration:** `BUSY` stays high for F = (PREAMBLE_LEN+32)·2·CLK_DIV cycles.
- **Frame end (cycle N+1+F):**
  - `DONE`=1, `BUSY`=0, `MDC`=0, `MDIO_OE`=0.
  - `DATA_RDY`=1 for reads.
  - `RD_DATA`/`TA_ERR` are valid in the same cycle.
- **Back-to-back:** a new start edge is accepted from the `DONE` cycle onward; the minimum frame-to-frame gap is 1 cycle.
- **Simultaneous `RESET` and start edge:** `RESET` wins.

## Test plan
- **C22 write:** CLK_DIV=2, PREAMBLE_LEN=32, `T_DATA`=32'h5440_8440.
  - `MDIO_OE`=1 for 256 cycles.
  - 32 ones, then the 32 bits of 5440_8440 MSB first, each stable for 4 cycles.
  - `DONE` at N+257; no `DATA_RDY`; `RD_DATA` stays 0.
- **C22 read:** `T_DATA`=32'h65C8_8440; PHY model drives Z/0 in TA then 16'hA5C3 MSB first.
  - `MDIO_OE` drops after 46 bits.
  - `RD_DATA`=16'hA5C3 with `DATA_RDY`=`DONE`=1 at N+257; `TA_ERR`=0.
- **Absent PHY:** same read with `MDIO_IN` tied 1.
  - `TA_ERR`=1, `RD_DATA`=16'hFFFF, `DATA_RDY` pulses.
  - Next accepted start clears `TA_ERR`.
- **Start while busy:** second `MDIO_START` edge 50 cycles into a write with different `T_DATA`.
  - Ignored; the serial stream is unchanged; exactly one `DONE`.
- **Reset mid-frame:** `RESET`=1 for 1 cycle at cycle N+100 of a read.
  - Next cycle: all outputs at reset values, no `DONE`.
  - `MDIO_START` held high across reset does not relaunch.
- **Parameter corner:** CLK_DIV=1, PREAMBLE_LEN=0, C45 address frame `T_DATA`=32'h0086_0123.
  - MDC period 2 cycles; no preamble; `BUSY` for 64 cycles; `DONE` only.
